fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, imem request/response FSM,
// next-PC selection for jal/jalr, misaligned-target fault and retire count.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] jal_target,
  input  logic [31:0] jalr_target,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault,
  output logic [31:0] retire_count
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID,
    FAULT
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] next_pc;
  logic [31:0] jalr_aligned;
  logic        misaligned;
  logic        do_retire;

  assign pc_plus4     = pc + 32'd4;
  assign jalr_aligned = jalr_target & ~32'h1;

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      unique case (pc_sel)
        2'b01:   next_pc = jal_target;
        2'b10:   next_pc = jalr_aligned;
        default: next_pc = pc_plus4;
      endcase
    end
  end

  // Only bit 1 marks a misaligned target; bit 0 is cleared for jalr.
  assign misaligned = next_pc[1];
  assign do_retire  = (state == VALID) && retire;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = REQ;
      REQ:     state_n = WAIT;
      WAIT:    if (imem_rvalid) state_n = VALID;
      VALID:   if (retire) state_n = misaligned ? FAULT : REQ;
      FAULT:   state_n = FAULT;
      default: state_n = IDLE;
    endcase
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == VALID);
  assign opcode      = instr_valid ? instr[6:0] : 7'b0000000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr        <= 32'h0;
      fault        <= 1'b0;
      retire_count <= 32'h0;
    end else begin
      state <= state_n;
      if (state == WAIT && imem_rvalid)
        instr <= imem_rdata;
      if (do_retire) begin
        retire_count <= retire_count + 32'd1;
        if (misaligned)
          fault <= 1'b1;
        else
          pc <= next_pc;
      end
    end
  end

endmodule
